// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states,
// the zero-register index and the per-stage write/flush bundle.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        TRAP  = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_wr;
        logic ifid_wr;
        logic ifid_flush;
        logic idex_wr;
        logic idex_flush;
        logic exmem_wr;
        logic memwb_wr;
        logic memwb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_ADVANCE = '{
        pc_wr:       1'b1,
        ifid_wr:     1'b1,
        ifid_flush:  1'b0,
        idex_wr:     1'b1,
        idex_flush:  1'b0,
        exmem_wr:    1'b1,
        memwb_wr:    1'b1,
        memwb_flush: 1'b0
    };

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard sequencer bundle: hazard inputs from ID/EX/MEM,
// stage-register enables and bubble strobes back to the datapath.
interface pipe_hazard_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       ex_memread;
    logic [4:0] ex_dst;
    logic       ex_br_taken;
    logic       mem_req;
    logic       mem_ready;

    logic       pc_wr;
    logic       ifid_wr;
    logic       ifid_flush;
    logic       idex_wr;
    logic       idex_flush;
    logic       exmem_wr;
    logic       memwb_wr;
    logic       memwb_flush;
    logic       mem_trap;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_memread, ex_dst, ex_br_taken,
        output mem_req, mem_ready,
        input  pc_wr, ifid_wr, ifid_flush,
        input  idex_wr, idex_flush, exmem_wr,
        input  memwb_wr, memwb_flush, mem_trap
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_memread, ex_dst, ex_br_taken,
        input  mem_req, mem_ready,
        output pc_wr, ifid_wr, ifid_flush,
        output idex_wr, idex_flush, exmem_wr,
        output memwb_wr, memwb_flush, mem_trap
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the ID sources and the EX load
// destination; also usable by the forwarding unit.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_dst,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_use_rs && (id_rs == ex_dst);
    assign rt_hit   = id_use_rt && (id_rt == ex_dst);
    assign load_use = ex_memread && (ex_dst != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stage enables/bubbles, dmem wait FSM, timeout trap.
// Optional PIPE_PERF_CNT_EN adds stall_cycles / flush_events counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic          clk,
    input  logic          rst,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]   stall_cycles,
    output logic [31:0]   flush_events,
`endif
    pipe_hazard_if.slave  hz
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_n;
    logic             mem_wait;
    logic             load_use;
    stage_ctrl_t      ctrl;

    hazard_detect u_hazard_detect (
        .id_rs      (hz.id_rs),
        .id_rt      (hz.id_rt),
        .id_use_rs  (hz.id_use_rs),
        .id_use_rt  (hz.id_use_rt),
        .ex_memread (hz.ex_memread),
        .ex_dst     (hz.ex_dst),
        .load_use   (load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        mem_wait   = 1'b0;
        unique case (state)
            RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    state_n    = MWAIT;
                    wait_cnt_n = CNT_W'(1);
                    mem_wait   = 1'b1;
                end
            end
            MWAIT: begin
                if (hz.mem_ready) begin
                    state_n    = RUN;
                    wait_cnt_n = '0;
                end else begin
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                    mem_wait   = 1'b1;
                    if (wait_cnt_n == CNT_MAX) state_n = TRAP;
                end
            end
            TRAP: begin
                state_n = TRAP;
            end
            default: begin
                state_n    = RUN;
                wait_cnt_n = '0;
            end
        endcase
    end

    // Priority: trap > mem wait > taken branch > load-use.
    always_comb begin
        ctrl = CTRL_ADVANCE;
        if (state == TRAP) begin
            ctrl = '0;
        end else if (mem_wait) begin
            ctrl             = '0;
            ctrl.memwb_wr    = 1'b1;
            ctrl.memwb_flush = 1'b1;
        end else if (hz.ex_br_taken) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_wr      = 1'b0;
            ctrl.ifid_wr    = 1'b0;
            ctrl.idex_flush = 1'b1;
        end
    end

    assign hz.pc_wr       = ctrl.pc_wr;
    assign hz.ifid_wr     = ctrl.ifid_wr;
    assign hz.ifid_flush  = ctrl.ifid_flush;
    assign hz.idex_wr     = ctrl.idex_wr;
    assign hz.idex_flush  = ctrl.idex_flush;
    assign hz.exmem_wr    = ctrl.exmem_wr;
    assign hz.memwb_wr    = ctrl.memwb_wr;
    assign hz.memwb_flush = ctrl.memwb_flush;
    assign hz.mem_trap    = (state == TRAP);

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!ctrl.pc_wr && (state != TRAP))
                stall_cycles <= stall_cycles + 32'd1;
            if (ctrl.ifid_flush)
                flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios then randomized traffic
// against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Model state: trapped flag and count of consecutive wait cycles so far.
    bit          m_trap;
    int          m_waits;
    int unsigned m_stall;
    int unsigned m_flush;

    pipe_hazard_if hz ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef PIPE_PERF_CNT_EN
        .stall_cycles (stall_cycles),
        .flush_events (flush_events),
`endif
        .hz           (hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] dut_out();
        return {hz.pc_wr, hz.ifid_wr, hz.ifid_flush, hz.idex_wr,
                hz.idex_flush, hz.exmem_wr, hz.memwb_wr,
                hz.memwb_flush, hz.mem_trap};
    endfunction

    function automatic bit model_wait();
        if (m_trap) return 1'b0;
        if (m_waits > 0) return !hz.mem_ready;
        return hz.mem_req && !hz.mem_ready;
    endfunction

    // {pc,ifid_wr,ifid_fl,idex_wr,idex_fl,exmem,memwb_wr,memwb_fl,trap}
    function automatic logic [8:0] model_out();
        bit lu;
        if (m_trap) return 9'b000000001;
        if (model_wait()) return 9'b000000110;
        if (hz.ex_br_taken) return 9'b111111100;
        lu = hz.ex_memread && (hz.ex_dst != 5'd0) &&
             ((hz.id_use_rs && hz.id_rs == hz.ex_dst) ||
              (hz.id_use_rt && hz.id_rt == hz.ex_dst));
        if (lu) return 9'b000111100;
        return 9'b110101100;
    endfunction

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt,
                          input logic mrd, input logic [4:0] dst,
                          input logic br, input logic req,
                          input logic rdy);
        hz.id_rs       = rs;
        hz.id_rt       = rt;
        hz.id_use_rs   = urs;
        hz.id_use_rt   = urt;
        hz.ex_memread  = mrd;
        hz.ex_dst      = dst;
        hz.ex_br_taken = br;
        hz.mem_req     = req;
        hz.mem_ready   = rdy;
    endtask

    task automatic idle_in();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs are set just after negedge; compare, then advance the model at posedge.
    task automatic cycle(input string tag);
        logic [8:0] exp;
        bit         w;
        #1;
        exp = model_out();
        check(tag, {23'd0, dut_out()}, {23'd0, exp});
`ifdef PIPE_PERF_CNT_EN
        check({tag, "_stall"}, stall_cycles, m_stall);
        check({tag, "_flush"}, flush_events, m_flush);
`endif
        w = model_wait();
        @(posedge clk);
        if (!rst) begin
            m_trap  = 1'b0;
            m_waits = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!m_trap && !exp[8]) m_stall++;
            if (exp[6]) m_flush++;
            if (w) begin
                m_waits++;
                if (m_waits == 16) m_trap = 1'b1;
            end else if (!m_trap) begin
                m_waits = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_in();
        cycle("reset");
        rst = 1'b1;
    endtask

    initial begin
        idle_in();
        m_trap  = 1'b0;
        m_waits = 0;
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        do_reset();

        // Idle: full advance, no trap.
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_pc", {31'd0, hz.pc_wr}, 32'd1);
            check("idle_trap", {31'd0, hz.mem_trap}, 32'd0);
            cycle("idle");
        end

        // Load-use on rs: exactly one stall cycle.
        set_in(5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        #1;
        check("lu_pc", {31'd0, hz.pc_wr}, 32'd0);
        check("lu_idexfl", {31'd0, hz.idex_flush}, 32'd1);
        cycle("lu");
        idle_in();
        cycle("lu_after");

        // Load to r0 never stalls.
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("lu_r0_pc", {31'd0, hz.pc_wr}, 32'd1);
        cycle("lu_r0");

        // dmem wait of 3 cycles, then completion.
        for (int i = 0; i < 4; i++) begin
            set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, i == 3);
            #1;
            check("mw_memwbfl", {31'd0, hz.memwb_flush}, {31'd0, i != 3});
            check("mw_exmem", {31'd0, hz.exmem_wr}, {31'd0, i == 3});
            cycle("mwait");
        end
        idle_in();
        cycle("mw_done");
`ifdef PIPE_PERF_CNT_EN
        check("perf_stall4", stall_cycles, 32'd4);
        check("perf_flush0", flush_events, 32'd0);
`endif

        // Taken branch plus load-use: squash, no stall.
        set_in(5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        check("br_pc", {31'd0, hz.pc_wr}, 32'd1);
        check("br_ififl", {31'd0, hz.ifid_flush}, 32'd1);
        cycle("br_lu");
        idle_in();
        cycle("br_after");
`ifdef PIPE_PERF_CNT_EN
        check("perf_flush1", flush_events, 32'd1);
`endif

        // Timeout: 16 wait cycles, trap on the 17th.
        for (int i = 0; i < 18; i++) begin
            set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            #1;
            check("to_trap", {31'd0, hz.mem_trap}, {31'd0, i >= 16});
            cycle("timeout");
        end
        do_reset();
        #1;
        check("post_rst_trap", {31'd0, hz.mem_trap}, 32'd0);
        check("post_rst_pc", {31'd0, hz.pc_wr}, 32'd1);

        // Randomized traffic, phases vary how often memory is ready.
        for (int ph = 0; ph < 6; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 3 : 60;
            for (int i = 0; i < 150; i++) begin
                rst = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
                set_in(5'($urandom_range(3)), 5'($urandom_range(3)),
                       1'($urandom), 1'($urandom),
                       1'($urandom), 5'($urandom_range(3)),
                       $urandom_range(99) < 20,
                       1'($urandom),
                       $urandom_range(99) < rdy_pct);
                cycle("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
